// File: rtl/mem_wb_pkg.sv
// Shared types for the MEM->WB skid stage: occupancy states and the write-back payload.
// Package defaults DATA_W/RD_W size the canonical payload struct.
package mem_wb_pkg;

    localparam int DATA_W = 32;
    localparam int RD_W   = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_result;
        logic [RD_W-1:0]   rd;
        logic              mem_to_reg;
        logic              reg_write;
    } mem_wb_payload_t;

endpackage

// File: rtl/mem_wb_entry.sv
// One payload slot of the MEM->WB skid stage: load-enabled register with synchronous clear.
module mem_wb_entry
    import mem_wb_pkg::*;
#(
    parameter type payload_t = mem_wb_payload_t
) (
    input  logic     clk,
    input  logic     i_clr,
    input  logic     i_load,
    input  payload_t i_d,
    output payload_t o_q
);

    payload_t r_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline stage with valid/ready handshake, two-entry skid buffer and flush.
// Define MEM_WB_STALL_CNT_EN to add the saturating stall_cnt output.
module mem_wb_skid_stage #(
    parameter int DATA_W = mem_wb_pkg::DATA_W,
    parameter int RD_W   = mem_wb_pkg::RD_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_mem_to_reg,
    input  logic              in_reg_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_mem_to_reg,
    output logic              out_reg_write
`ifdef MEM_WB_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    import mem_wb_pkg::*;

    typedef struct packed {
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_result;
        logic [RD_W-1:0]   rd;
        logic              mem_to_reg;
        logic              reg_write;
    } payload_t;

    occ_state_e r_state;
    occ_state_e w_state_nxt;
    logic       r_in_ready;
    logic       r_out_valid;

    logic       w_accept;
    logic       w_consume;
    logic       w_load_main;
    logic       w_load_skid;
    logic       w_main_from_skid;

    payload_t   w_in_payload;
    payload_t   w_main_d;
    payload_t   w_main_q;
    payload_t   w_skid_q;

    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_out_valid && out_ready;

    assign w_in_payload = '{
        mem_data:   in_mem_data,
        alu_result: in_alu_result,
        rd:         in_rd,
        mem_to_reg: in_mem_to_reg,
        reg_write:  in_reg_write
    };

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = FULL1;
                    w_load_main = 1'b1;
                end
            end
            FULL1: begin
                if (w_accept && !w_consume) begin
                    w_state_nxt = FULL2;
                    w_load_skid = 1'b1;
                end else if (w_accept && w_consume) begin
                    w_load_main = 1'b1;
                end else if (w_consume) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL2: begin
                if (w_consume) begin
                    w_state_nxt      = FULL1;
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        // Flush wins over both handshakes; the main slot keeps its stale payload.
        if (flush) begin
            w_state_nxt = EMPTY;
            w_load_main = 1'b0;
            w_load_skid = 1'b0;
        end
    end

    // in_ready/out_valid are flops decoded from the next state, keeping out_ready off the in_ready path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt != FULL2);
            r_out_valid <= (w_state_nxt != EMPTY);
        end
    end

    assign w_main_d = w_main_from_skid ? w_skid_q : w_in_payload;

    mem_wb_entry #(.payload_t(payload_t)) u_main (
        .clk    (clk),
        .i_clr  (!rst_n),
        .i_load (w_load_main),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    mem_wb_entry #(.payload_t(payload_t)) u_skid (
        .clk    (clk),
        .i_clr  (!rst_n || flush),
        .i_load (w_load_skid),
        .i_d    (w_in_payload),
        .o_q    (w_skid_q)
    );

    assign in_ready       = r_in_ready;
    assign out_valid      = r_out_valid;
    assign out_mem_data   = w_main_q.mem_data;
    assign out_alu_result = w_main_q.alu_result;
    assign out_rd         = w_main_q.rd;
    assign out_mem_to_reg = w_main_q.mem_to_reg;
    assign out_reg_write  = w_main_q.reg_write && r_out_valid;

`ifdef MEM_WB_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Self-checking bench for mem_wb_skid_stage: directed scenarios plus random traffic against a queue model.
module tb_mem_wb_skid_stage;

    import mem_wb_pkg::*;

    localparam int DATA_W  = 32;
    localparam int RD_W    = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_mem_data;
    logic [DATA_W-1:0] in_alu_result;
    logic [RD_W-1:0]   in_rd;
    logic              in_mem_to_reg;
    logic              in_reg_write;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_mem_data;
    logic [DATA_W-1:0] out_alu_result;
    logic [RD_W-1:0]   out_rd;
    logic              out_mem_to_reg;
    logic              out_reg_write;
`ifdef MEM_WB_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    mem_wb_skid_stage #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mem_data    (in_mem_data),
        .in_alu_result  (in_alu_result),
        .in_rd          (in_rd),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_reg_write   (in_reg_write),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_mem_data   (out_mem_data),
        .out_alu_result (out_alu_result),
        .out_rd         (out_rd),
        .out_mem_to_reg (out_mem_to_reg),
        .out_reg_write  (out_reg_write)
`ifdef MEM_WB_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a FIFO of at most two entries plus the last payload shown on the outputs.
    mem_wb_payload_t m_q[$];
    mem_wb_payload_t m_last = '0;
    int              m_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic mem_wb_payload_t cur_input();
        mem_wb_payload_t p;
        p.mem_data   = in_mem_data;
        p.alu_result = in_alu_result;
        p.rd         = in_rd;
        p.mem_to_reg = in_mem_to_reg;
        p.reg_write  = in_reg_write;
        return p;
    endfunction

    // Advance one clock, update the model from the inputs seen at that edge, then compare all outputs.
    task automatic step();
        bit had;
        bit room;
        @(posedge clk);
        had  = (m_q.size() > 0);
        room = (m_q.size() < 2);
        if (!rst_n) begin
            m_q.delete();
            m_last = '0;
            m_cnt  = 0;
        end else begin
            if (had && !out_ready && m_cnt < CNT_MAX) m_cnt++;
            if (flush) begin
                m_q.delete();
            end else begin
                if (had && out_ready) void'(m_q.pop_front());
                if (in_valid && room) m_q.push_back(cur_input());
            end
            if (m_q.size() > 0) m_last = m_q[0];
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
        check("in_ready", 64'(in_ready), 64'(m_q.size() < 2));
        check("out_reg_write", 64'(out_reg_write), 64'((m_q.size() > 0) && m_last.reg_write));
        check("out_alu_result", 64'(out_alu_result), 64'(m_last.alu_result));
        check("out_mem_data", 64'(out_mem_data), 64'(m_last.mem_data));
        check("out_rd", 64'(out_rd), 64'(m_last.rd));
        check("out_mem_to_reg", 64'(out_mem_to_reg), 64'(m_last.mem_to_reg));
`ifdef MEM_WB_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
`endif
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] alu, input logic rw);
        in_valid      = v;
        in_alu_result = alu;
        in_mem_data   = $urandom;
        in_rd         = RD_W'($urandom);
        in_mem_to_reg = 1'($urandom);
        in_reg_write  = rw;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_alu", 64'(out_alu_result), 64'd0);

        // Stream: one per cycle, visible one cycle after accept.
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, DATA_W'(k), 1'b1);
            step();
            check("stream_alu", 64'(out_alu_result), 64'(k));
            check("stream_valid", 64'(out_valid), 64'd1);
        end
        drive(1'b0, '0, 1'b0);
        step();
        check("stream_drain", 64'(out_valid), 64'd0);

        // Backpressure: A, B fill the stage, C waits, then all drain in order.
        out_ready = 1'b0;
        drive(1'b1, 32'h10, 1'b1);
        step();
        drive(1'b1, 32'h20, 1'b1);
        step();
        check("bp_full_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h30, 1'b1);
        step();
        check("bp_hold_a", 64'(out_alu_result), 64'h10);
        out_ready = 1'b1;
        step();
        check("bp_b", 64'(out_alu_result), 64'h20);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        step();
        check("bp_c", 64'(out_alu_result), 64'h30);
        drive(1'b0, '0, 1'b0);
        step();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Flush while full with a new input presented.
        out_ready = 1'b0;
        drive(1'b1, 32'h41, 1'b1);
        step();
        drive(1'b1, 32'h42, 1'b1);
        step();
        flush = 1'b1;
        drive(1'b1, 32'h99, 1'b1);
        step();
        flush = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_rw", 64'(out_reg_write), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        drive(1'b0, '0, 1'b0);
        out_ready = 1'b1;
        step();
        check("flush_no_ghost", 64'(out_valid), 64'd0);

        // Bubble gating: reg_write drops while rd keeps its old value.
        drive(1'b1, 32'h55, 1'b1);
        in_rd = 5'd7;
        step();
        check("bubble_rw_live", 64'(out_reg_write), 64'd1);
        drive(1'b0, '0, 1'b0);
        step();
        check("bubble_rw", 64'(out_reg_write), 64'd0);
        check("bubble_rd", 64'(out_rd), 64'd7);

        // Reset while stalled and full.
        out_ready = 1'b0;
        drive(1'b1, 32'h61, 1'b1);
        step();
        drive(1'b1, 32'h62, 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        do_reset();
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_ready", 64'(in_ready), 64'd1);
        check("rst_mid_alu", 64'(out_alu_result), 64'd0);

        // Long stall: the counter saturates at its all-ones value.
        drive(1'b1, 32'h77, 1'b0);
        step();
        drive(1'b0, '0, 1'b0);
        for (int i = 0; i < 20; i++) step();
`ifdef MEM_WB_STALL_CNT_EN
        check("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
`endif
        check("stall_hold", 64'(out_alu_result), 64'h77);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rst_n     = ($urandom_range(0, 63) != 0);
            step();
        end
        rst_n = 1'b1;
        flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
